counter_display_driver: RTL
===========================

Name: counter_display_driver

Overview:
- Downstream consumer of the up/down counter stage. Takes the counter value and its one-cycle `ack` pulse.
- Drives a multiplexed common-anode seven-segment display, showing the value in hex one digit at a time.
- Stretches `ack` into a visible LED pulse.
- Sits between the counter and the board display pins.

Parameters:
- DATA_SIZE, 4: width of `value`; must be a multiple of 4. NUM_DIGITS = DATA_SIZE/4.
- SCAN_BITS, 16: prescaler width. One digit period = 2^SCAN_BITS clocks.
- ACK_HOLD_BITS, 22: `ackLed` hold = 2^ACK_HOLD_BITS-1 clocks.
- ACTIVE_LOW, 1: 1 = `segments` and `anodes` active-low; 0 = active-high.

Ports:
- clock  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- value  input  DATA_SIZE  counter value to display.
- ack  input  1  one-cycle pulse from the counter stage.
- segments  output  7  {g,f,e,d,c,b,a}, registered.
- anodes  output  NUM_DIGITS  one-hot digit enable, registered; bit 0 = least-significant nibble.
- ackLed  output  1  stretched ack indicator, registered.

Behaviour:
- Reset (reset low, async) clears all state:
  - anodes all inactive; segments all off (all 1s if ACK_LOW=1... i.e. if ACTIVE_LOW=1); ackLed=0.
  - prescaler=0, digit index=0, snapshot=0, FSM=BLANK.
- Prescaler:
  - Free-running SCAN_BITS counter.
  - scanTick = 1 for one cycle when the count is all ones; wraps to 0.
- Digit index:
  - Advances on scanTick.
  - Wraps NUM_DIGITS-1 -> 0.
- Snapshot register:
  - Loads `value` on the scanTick where index == NUM_DIGITS-1, i.e. at the frame boundary.
  - A frame therefore never mixes old and new nibbles.
  - Worst-case display latency = NUM_DIGITS*2^SCAN_BITS + 2 clocks.
- Two-state FSM, SHOW / BLANK (anti-ghosting):
  - Cycle T, scanTick in SHOW: go to BLANK at T+1. At T+1: anodes all inactive; segments = glyph of the new index's nibble.
  - In BLANK: go to SHOW at T+2. At T+2: only the anode of the new index is active.
  - SHOW holds until the next scanTick.
  - Exit from reset goes BLANK -> SHOW on the first clock; digit 0 is shown with snapshot 0.
- Hex glyphs, active-high {g..a}:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100
  - C=0111001, d=1011110, E=1111001, F=1110001
  - ACTIVE_LOW=1 inverts both segments and anodes at the output register.
- Ack stretcher:
  - `ack` high loads the hold counter with 2^ACK_HOLD_BITS-1.
  - ackLed = (hold counter != 0), registered. It rises the cycle after `ack` and decrements each cycle.
  - `ack` arriving while the counter is nonzero reloads it (retrigger). No saturation or wrap below 0.
- `value` changing every cycle is legal; only the frame-boundary sample is displayed.
- Reset asserted mid-frame or mid-hold forces the reset values immediately. No partial-digit output.

Optional Feature:
- Macro: COUNTER_DISPLAY_LEADING_ZERO_BLANK_EN.
- Defined:
  - Any digit whose nibble and all higher nibbles of the snapshot are zero is blanked. In SHOW its anode stays inactive and segments are off.
  - Digit 0 is always shown, even for value 0.
  - Scan timing is unchanged.
- Undefined: all digits are always shown, including leading zeros.

Test Plan:
- Settings for all scenarios: DATA_SIZE=8, SCAN_BITS=2, ACK_HOLD_BITS=3, ACTIVE_LOW=1.
- Reset: hold reset low with value=8'hFF, ack=1 -> anodes=2'b11, segments=7'h7F, ackLed=0 throughout. Release -> anodes=2'b10 next cycle, segments=7'h40 ("0").
- Steady value=8'h3A after one full frame:
  - Digit 0: anodes=2'b10, segments=7'h08 ("A").
  - Then one BLANK cycle: anodes=2'b11.
  - Digit 1: anodes=2'b01, segments=7'h30 ("3").
  - Period 4 clocks per digit.
- Frame consistency: value 8'h3A -> 8'hC5 while digit 0 is shown -> digit 1 still shows "3" this frame. The next frame shows "5" (7'h12) then "C" (7'h46). No mixed frame.
- Ack: single-cycle ack at cycle 10 -> ackLed=1 on cycles 11..17 (7 cycles), 0 at 18. A second ack at cycle 14 -> ackLed held through cycle 21.
- Mid-operation reset: assert reset during ackLed=1 and the digit-1 SHOW state -> outputs go to reset values with no clock edge. After release, scanning restarts at digit 0 with snapshot 0.
- With COUNTER_DISPLAY_LEADING_ZERO_BLANK_EN defined, value=8'h05 -> anode bit 1 never active and digit 0 shows 7'h12. value=8'h00 -> digit 0 shows 7'h40. Without the macro, digit 1 shows 7'h40.

Source files
------------

// File: rtl/counter_display_driver.sv
// Multiplexed common-anode hex display driver with frame-consistent snapshot and ack LED stretcher.
// Optional: define COUNTER_DISPLAY_LEADING_ZERO_BLANK_EN to blank leading-zero digits (digit 0 always shown).
module counter_display_driver #(
  parameter int DATA_SIZE     = 4,
  parameter int SCAN_BITS     = 16,
  parameter int ACK_HOLD_BITS = 22,
  parameter int ACTIVE_LOW    = 1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [DATA_SIZE-1:0]   value,
  input  logic                   ack,
  output logic [6:0]             segments,
  output logic [DATA_SIZE/4-1:0] anodes,
  output logic                   ackLed
);

  localparam int NUM_DIGITS = DATA_SIZE / 4;
  localparam int IDX_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic POL = (ACTIVE_LOW != 0);

  typedef enum logic {
    BLANK,
    SHOW
  } state_t;

  state_t                   state, state_next;
  logic [SCAN_BITS-1:0]     prescaler;
  logic                     scan_tick;
  logic [IDX_W-1:0]         idx, idx_next;
  logic [DATA_SIZE-1:0]     snapshot, snapshot_next;
  logic [ACK_HOLD_BITS-1:0] hold, hold_next;
  logic [3:0]               nibble_next;
  logic                     digit_blank;
  logic [NUM_DIGITS-1:0]    anodes_next;
  logic [6:0]               segments_next;

  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0:    hex_glyph = 7'b0111111;
      4'h1:    hex_glyph = 7'b0000110;
      4'h2:    hex_glyph = 7'b1011011;
      4'h3:    hex_glyph = 7'b1001111;
      4'h4:    hex_glyph = 7'b1100110;
      4'h5:    hex_glyph = 7'b1101101;
      4'h6:    hex_glyph = 7'b1111101;
      4'h7:    hex_glyph = 7'b0000111;
      4'h8:    hex_glyph = 7'b1111111;
      4'h9:    hex_glyph = 7'b1101111;
      4'hA:    hex_glyph = 7'b1110111;
      4'hB:    hex_glyph = 7'b1111100;
      4'hC:    hex_glyph = 7'b0111001;
      4'hD:    hex_glyph = 7'b1011110;
      4'hE:    hex_glyph = 7'b1111001;
      default: hex_glyph = 7'b1110001;
    endcase
  endfunction

  assign scan_tick = &prescaler;

  // The snapshot only reloads when scanning wraps back to digit 0, so a frame never mixes values.
  always_comb begin
    idx_next      = idx;
    snapshot_next = snapshot;
    if (scan_tick) begin
      if (idx == LAST_IDX) begin
        idx_next      = '0;
        snapshot_next = value;
      end else begin
        idx_next = idx + IDX_W'(1);
      end
    end
  end

  always_comb begin
    nibble_next = '0;
    for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
      if (idx_next == IDX_W'(d)) nibble_next = snapshot_next[4*d +: 4];
    end
  end

`ifdef COUNTER_DISPLAY_LEADING_ZERO_BLANK_EN
  assign digit_blank = (idx_next != '0) && ((snapshot_next >> {idx_next, 2'b00}) == '0);
`else
  assign digit_blank = 1'b0;
`endif

  // Outputs are computed from next-state values so the registered pins line up with the FSM.
  always_comb begin
    state_next    = state;
    anodes_next   = '0;
    segments_next = hex_glyph(nibble_next);
    case (state)
      BLANK:   state_next = SHOW;
      SHOW:    if (scan_tick) state_next = BLANK;
      default: state_next = BLANK;
    endcase
    if (state_next == SHOW) begin
      for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
        anodes_next[d] = (idx_next == IDX_W'(d));
      end
    end
    if (digit_blank) begin
      anodes_next   = '0;
      segments_next = '0;
    end
  end

  always_comb begin
    hold_next = hold;
    if (ack) begin
      hold_next = '1;
    end else if (hold != '0) begin
      hold_next = hold - ACK_HOLD_BITS'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prescaler <= '0;
      idx       <= '0;
      snapshot  <= '0;
      state     <= BLANK;
      hold      <= '0;
      segments  <= {7{POL}};
      anodes    <= {NUM_DIGITS{POL}};
      ackLed    <= 1'b0;
    end else begin
      prescaler <= prescaler + SCAN_BITS'(1);
      idx       <= idx_next;
      snapshot  <= snapshot_next;
      state     <= state_next;
      hold      <= hold_next;
      segments  <= segments_next ^ {7{POL}};
      anodes    <= anodes_next ^ {NUM_DIGITS{POL}};
      ackLed    <= (hold_next != '0);
    end
  end

endmodule
